// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file peripheral: synchronises the SPI pins into clk, frames R/W + address + data, commits writes.
// Define SPI_REGFILE_READBACK_EN to build the cipo read path; otherwise cipo/cipo_oe are tied low.
module spi_regfile_peripheral #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_pulse,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_HDR  = CNT_W'(1 + ADDR_W);
    localparam logic [ADDR_W:0]   NREGS    = (ADDR_W + 1)'(NUM_REGS);

    logic [SYNC_STAGES-1:0] sclk_sync_q, ncs_sync_q, copi_sync_q;
    logic                   sclk_prev_q, ncs_prev_q;
    logic                   sclk_s, ncs_s, copi_s;
    logic                   sclk_rise, ncs_fall, ncs_rise;

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]        rx_q, rx_d;
    logic                        over_q, over_d;
    logic [NUM_REGS*DATA_W-1:0]  regs_q, regs_d;
    logic                        wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
    logic                        frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]           fr_addr;
    logic [DATA_W-1:0]           fr_data;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign fr_addr   = rx_q[DATA_W +: ADDR_W];
    assign fr_data   = rx_q[DATA_W-1:0];

    // chip select idles high so the sync chain resets to 1 to avoid a false frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            copi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            sclk_prev_q <= sclk_s;
            ncs_prev_q  <= ncs_s;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        over_d      = over_q;
        regs_d      = regs_q;
        wr_pulse_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        if (ncs_fall) begin
            cnt_d  = '0;
            rx_d   = '0;
            over_d = 1'b0;
        end else if (ncs_rise) begin
            if (cnt_q != '0) begin
                if (cnt_q != CNT_FULL || over_q) begin
                    frame_err_d = 1'b1;
                end else if (rx_q[FRAME_LEN-1] && ({1'b0, fr_addr} < NREGS)) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (fr_addr == ADDR_W'(k)) regs_d[k*DATA_W +: DATA_W] = fr_data;
                    end
                    wr_pulse_d = 1'b1;
                    wr_addr_d  = fr_addr;
                end
            end
        end else if (!ncs_s && sclk_rise) begin
            if (cnt_q == CNT_FULL) begin
                over_d = 1'b1;
            end else begin
                rx_d  = {rx_q[FRAME_LEN-2:0], copi_s};
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            rx_q        <= '0;
            over_q      <= 1'b0;
            regs_q      <= '0;
            wr_pulse_q  <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            over_q      <= over_d;
            regs_q      <= regs_d;
            wr_pulse_q  <= wr_pulse_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign regs_flat = regs_q;
    assign wr_pulse  = wr_pulse_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

`ifdef SPI_REGFILE_READBACK_EN
    logic              sclk_fall;
    logic [DATA_W-1:0] tx_q, tx_d, rd_sel;
    logic              cipo_q, cipo_d, oe_q, oe_d;

    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // the first falling edge after the header loads the shifter and presents its MSB in one step
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rx_q[ADDR_W-1:0] == ADDR_W'(k)) rd_sel = regs_q[k*DATA_W +: DATA_W];
        end
        tx_d   = tx_q;
        cipo_d = cipo_q;
        oe_d   = oe_q;
        if (ncs_fall || ncs_rise) begin
            tx_d   = '0;
            cipo_d = 1'b0;
            oe_d   = 1'b0;
        end else if (!ncs_s && sclk_fall) begin
            if (cnt_q == CNT_HDR && !rx_q[ADDR_W]) begin
                oe_d           = 1'b1;
                {cipo_d, tx_d} = {rd_sel, 1'b0};
            end else if (oe_q && cnt_q < CNT_FULL) begin
                cipo_d = tx_q[DATA_W-1];
                tx_d   = tx_q << 1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q   <= '0;
            cipo_q <= 1'b0;
            oe_q   <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            cipo_q <= cipo_d;
            oe_q   <= oe_d;
        end
    end

    assign cipo    = cipo_q;
    assign cipo_oe = oe_q;
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Randomised scoreboard bench for spi_regfile_peripheral at default parameters.
module tb_spi_regfile_peripheral;
    localparam int HALF = 6;
    localparam int GAP  = 5;
`ifdef SPI_REGFILE_READBACK_EN
    localparam int OE_BITS = 8;
`else
    localparam int OE_BITS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        ncs = 1'b1;
    logic        copi = 1'b0;
    logic        cipo, cipo_oe, wr_pulse, frame_err;
    logic [39:0] regs_flat;
    logic [6:0]  wr_addr;

    spi_regfile_peripheral dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
        .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
        .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;
    typedef struct {
        logic [7:0] data;
        int         oe_cnt;
    } rd_t;

    ev_t        ev_q[$];
    logic [7:0] rd_exp[$];
    rd_t        rd_got[$];
    logic [7:0] model[5];
    int         checks = 0;
    int         errors = 0;
    int         stray_tx = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [39:0] model_flat();
        logic [39:0] f;
        for (int k = 0; k < 5; k++) f[k*8 +: 8] = model[k];
        return f;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // clocks n bits MSB first; captures the read data window when sample is set
    task automatic send_bits(input logic [31:0] bits, input int n, input bit sample);
        rd_t r;
        r.data = '0;
        r.oe_cnt = 0;
        for (int i = 0; i < n; i++) begin
            copi = bits[n-1-i];
            wait_clk(2);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
            wait_clk(HALF);
            if (sample && i >= 7 && i <= 14) begin
                r.data = {r.data[6:0], cipo};
                if (cipo_oe) r.oe_cnt++;
            end
        end
        if (sample) rd_got.push_back(r);
    endtask

    task automatic issue(input logic [31:0] bits, input int n);
        logic [6:0] a;
        logic [7:0] d;
        a = bits[14:8];
        d = bits[7:0];
        if (n == 16) begin
            if (bits[15]) begin
                if (a < 7'd5) begin
                    model[a] = d;
                    ev_q.push_back('{1'b0, a, d});
                end
            end else begin
`ifdef SPI_REGFILE_READBACK_EN
                rd_exp.push_back(a < 7'd5 ? model[a] : 8'h00);
`else
                rd_exp.push_back(8'h00);
`endif
            end
        end else if (n > 0) begin
            ev_q.push_back('{1'b1, 7'd0, 8'd0});
        end
        ncs = 1'b0;
        wait_clk(HALF);
        send_bits(bits, n, n == 16 && !bits[15]);
        ncs = 1'b1;
        wait_clk(GAP);
    endtask

    task automatic monitor();
        ev_t e;
        rd_t g;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (wr_pulse || frame_err) begin
                    if (ev_q.size() == 0) begin
                        check("unexpected_event", {wr_pulse, frame_err}, 2'b00);
                    end else begin
                        e = ev_q.pop_front();
                        check("event_kind_err", frame_err, e.is_err);
                        check("event_kind_wr", wr_pulse, !e.is_err);
                        if (!e.is_err) begin
                            check("wr_addr", wr_addr, e.addr);
                            check("reg_commit", regs_flat[int'(e.addr)*8 +: 8], e.data);
                        end
                    end
                end
                if (rd_got.size() > 0) begin
                    g = rd_got.pop_front();
                    if (rd_exp.size() == 0) begin
                        check("unexpected_read", 1, 0);
                    end else begin
                        check("read_data", g.data, rd_exp.pop_front());
                        check("read_oe_bits", g.oe_cnt, OE_BITS);
                    end
                end
`ifndef SPI_REGFILE_READBACK_EN
                if (cipo || cipo_oe) stray_tx++;
`endif
            end
        end
    endtask

    initial begin
        int r, n;
        logic [6:0] a;
        logic [31:0] b;
        for (int k = 0; k < 5; k++) model[k] = 8'h00;
        wait_clk(3);
        #1;
        check("rst_regs", regs_flat, 40'h0);
        check("rst_wr_addr", wr_addr, 7'h0);
        check("rst_wr_pulse", wr_pulse, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_cipo", cipo, 1'b0);
        check("rst_cipo_oe", cipo_oe, 1'b0);
        rst = 1'b0;
        fork
            monitor();
        join_none
        wait_clk(4);

        issue(32'h84A5, 16);
        check("after_write_84A5", regs_flat, model_flat());
        issue(32'h8233, 16);
        issue(32'h0200, 16);
        issue(32'h0400, 16);
        issue(32'h85FF, 16);
        issue(32'h0700, 16);
        check("after_oor_write", regs_flat, model_flat());
        issue(32'h4000, 15);
        issue(32'h10000, 17);
        check("after_bad_len", regs_flat, model_flat());

        // reset in the middle of a write frame
        ncs = 1'b0;
        wait_clk(HALF);
        send_bits(32'h81FF >> 6, 10, 1'b0);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) model[k] = 8'h00;
        ncs = 1'b1;
        wait_clk(GAP + 3);
        #1;
        check("midframe_rst_regs", regs_flat, 40'h0);
        check("midframe_rst_wr_addr", wr_addr, 7'h0);
        issue(32'h8011, 16);
        issue(32'h0100, 16);
        check("after_rst_write", regs_flat, model_flat());

        issue(32'h8001, 16);
        issue(32'h8002, 16);
        issue(32'h0000, 16);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            a = 7'($urandom_range(0, 6));
            if (r <= 4) begin
                issue({16'h0, 1'b1, a, 8'($urandom)}, 16);
            end else if (r <= 7) begin
                issue({16'h0, 1'b0, a, 8'($urandom)}, 16);
            end else begin
                n = $urandom_range(1, 19);
                if (n >= 16) n++;
                b = $urandom;
                issue(b & ((32'h1 << n) - 1), n);
            end
        end

        wait_clk(30);
        check("final_regs", regs_flat, model_flat());
        check("events_drained", ev_q.size(), 0);
        check("reads_drained", rd_exp.size() + rd_got.size(), 0);
        check("no_stray_cipo", stray_tx, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
